// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps a 3-input evaluator through all 8 vectors, captures and checks its truth table (optional TT_FIRST_FAIL_EN)
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass,
`ifdef TT_FIRST_FAIL_EN
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid,
`endif
  output logic [3:0] mismatch_count
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  state_t state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] exp_l;
  logic [7:0] res_n;
  logic miss;
  assign {B, C, D} = (state == S_DRIVE || state == S_SAMPLE) ? idx : 3'd0;
  // result as it will look once the current vector's Y is folded in
  always_comb begin
    res_n = result;
    res_n[idx] = y_in;
    miss = y_in != exp_l[idx];
  end
  // sweep sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      exp_l <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      pass <= 1'b0;
      mismatch_count <= '0;
`ifdef TT_FIRST_FAIL_EN
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          exp_l <= expected;
          result <= '0;
          mismatch_count <= '0;
          pass <= 1'b0;
          idx <= '0;
          busy <= 1'b1;
          cnt <= RELOAD;
          state <= S_DRIVE;
`ifdef TT_FIRST_FAIL_EN
          first_fail_idx <= '0;
          first_fail_valid <= 1'b0;
`endif
        end
        S_DRIVE: if (cnt == '0) state <= S_SAMPLE; else cnt <= cnt - 4'd1;
        S_SAMPLE: begin
          result <= res_n;
          if (miss) mismatch_count <= mismatch_count + 4'd1;
`ifdef TT_FIRST_FAIL_EN
          if (miss && !first_fail_valid) begin
            first_fail_idx <= idx;
            first_fail_valid <= 1'b1;
          end
`endif
          if (idx == 3'd7) begin
            state <= S_DONE;
            done <= 1'b1;
            busy <= 1'b0;
            pass <= res_n == exp_l;
          end else begin
            idx <= idx + 3'd1;
            cnt <= RELOAD;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
